// File: rtl/fir_dmac.sv
// DMA sequencer for the 3x3 FIR core: loads 9 coefficients, streams one window per output pixel,
// and writes each filter result back. Define FIR_DMAC_TIMEOUT_EN to add the WAIT_CORE timeout and err flag.
module fir_dmac #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 12,
  parameter int N      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] tc_base,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N-1:0]      input_data,
  output logic              valid_dmac,
  output logic              tc_set,
  input  logic [N-1:0]      output_data,
  input  logic              valid_core,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic              busy,
  output logic              done
`ifdef FIR_DMAC_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_TC = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]     C_LAST   = CW'(IMG_W - 3);
  localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H - 3);
  // j=2 -> j=0 of the next window row; last column -> first column of the next output row
  localparam logic [ADDR_W-1:0] ROW_SKIP = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_WRAP = ADDR_W'(3);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      data;
  } wr_req_t;

  logic [2:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] win_ptr;
  logic [ADDR_W-1:0] win_nxt;
  logic [3:0]        kcnt;
  logic [1:0]        jcnt;
  logic [CW-1:0]     ccnt;
  logic [RW-1:0]     rcnt;
  wr_req_t           wreq;
  logic [1:0]        vld_pipe;
  logic              tc_pipe;
  logic              last_px;
`ifdef FIR_DMAC_TIMEOUT_EN
  logic [4:0]        tmo_cnt;
`endif

  assign last_px = (ccnt == C_LAST) && (rcnt == R_LAST);
  assign win_nxt = (ccnt == C_LAST) ? win_ptr + ROW_WRAP : win_ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_ptr  <= '0;
      win_ptr <= '0;
      kcnt    <= '0;
      jcnt    <= '0;
      ccnt    <= '0;
      rcnt    <= '0;
      wreq    <= '0;
`ifdef FIR_DMAC_TIMEOUT_EN
      tmo_cnt <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state     <= S_LOAD_TC;
          rd_ptr    <= tc_base;
          win_ptr   <= src_base;
          wreq.addr <= dst_base;
          kcnt      <= '0;
          ccnt      <= '0;
          rcnt      <= '0;
`ifdef FIR_DMAC_TIMEOUT_EN
          err       <= 1'b0;
`endif
        end
        S_LOAD_TC: begin
          rd_ptr <= rd_ptr + 1'b1;
          kcnt   <= kcnt + 1'b1;
          if (kcnt == 4'd8) begin
            state  <= S_FETCH;
            rd_ptr <= win_ptr;
            kcnt   <= '0;
            jcnt   <= '0;
          end
        end
        S_FETCH: begin
          kcnt <= kcnt + 1'b1;
          if (jcnt == 2'd2) begin
            jcnt   <= '0;
            rd_ptr <= rd_ptr + ROW_SKIP;
          end else begin
            jcnt   <= jcnt + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (kcnt == 4'd8) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state <= S_WAIT;
`ifdef FIR_DMAC_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (valid_core) begin
            wreq.data <= output_data;
            state     <= S_WRITE;
          end
`ifdef FIR_DMAC_TIMEOUT_EN
          else if (tmo_cnt == 5'd15) begin
            err   <= 1'b1;
            state <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_WRITE: begin
          wreq.addr <= wreq.addr + 1'b1;
          kcnt      <= '0;
          jcnt      <= '0;
          if (last_px) begin
            state <= S_FINISH;
          end else begin
            state   <= S_FETCH;
            win_ptr <= win_nxt;
            rd_ptr  <= win_nxt;
            if (ccnt == C_LAST) begin
              ccnt <= '0;
              rcnt <= rcnt + 1'b1;
            end else begin
              ccnt <= ccnt + 1'b1;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // read data arrives one cycle after the strobe, so the valid/tc flags ride one stage behind rd_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      tc_pipe     <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      tc_pipe     <= (state == S_LOAD_TC);
    end
  end

  assign vld_pipe[0] = (state == S_LOAD_TC) || (state == S_FETCH);
  assign rd_en       = vld_pipe[0];
  assign rd_addr     = rd_en ? rd_ptr : '0;
  assign valid_dmac  = vld_pipe[1];
  assign tc_set      = tc_pipe;
  assign input_data  = vld_pipe[1] ? rd_data : '0;
  assign wr_en       = (state == S_WRITE);
  assign wr_addr     = wr_en ? wreq.addr : '0;
  assign wr_data     = wr_en ? wreq.data : '0;
  assign busy        = (state != S_IDLE) && (state != S_FINISH);
  assign done        = (state == S_FINISH);

endmodule

// File: tb/tb_fir_dmac.sv
// Scoreboard bench for fir_dmac with a memory model and a reactive filter-core model.
module tb_fir_dmac;
  localparam int W = 4, H = 4, AW = 12, N = 24;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] tc_base, src_base, dst_base;
  logic rd_en, valid_dmac, tc_set, valid_core, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [N-1:0] rd_data, input_data, output_data, wr_data;
`ifdef FIR_DMAC_TIMEOUT_EN
  logic err;
`endif

  always #5 clk = ~clk;

  fir_dmac #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tc_base(tc_base), .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .input_data(input_data), .valid_dmac(valid_dmac), .tc_set(tc_set),
    .output_data(output_data), .valid_core(valid_core),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
`ifdef FIR_DMAC_TIMEOUT_EN
    , .err(err)
`endif
  );

  logic [N-1:0] mem [0:4095];
  int total = 0, bad = 0, cyc = 0;
  logic [AW-1:0]   rd_q [$];
  logic [N:0]      in_q [$];
  logic [AW+N-1:0] wr_q [$];
  int              wr_cyc [$];
  bit mon_en = 0, core_en = 0, waiting = 0, vc_prev = 0, pend_rd = 0;
  int wr_cnt = 0, done_cnt = 0, tcset_cnt = 0, core_delay = 2, left = 0, kc = 0, pc = 0, last_pix_cyc = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [8:0][N-1:0] ccoef, cpix;

  function automatic logic [N-1:0] conv(input logic [8:0][N-1:0] c, input logic [8:0][N-1:0] p);
    logic [N-1:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int s;
      s = 0;
      for (int k = 0; k < 9; k++) s += int'(c[k][ch*8 +: 8]) * int'(p[k][ch*8 +: 8]);
      res[ch*8 +: 8] = s[7:0];
    end
    return res;
  endfunction

  always @(posedge clk) cyc++;

  // memory read port and filter-core response, driven just after the edge
  always @(posedge clk) begin
    #1;
    rd_data = pend_rd ? mem[pend_addr] : N'($urandom);
    if (left > 0) begin
      left--;
      if (left == 0) begin
        valid_core  = 1'b1;
        output_data = conv(ccoef, cpix);
      end else begin
        valid_core = 1'b0;
      end
    end else begin
      valid_core  = 1'b0;
      output_data = N'($urandom);
    end
  end

  // mid-cycle monitor: memory requests, core capture, scoreboard
  always @(negedge clk) begin
    pend_rd   = rd_en;
    pend_addr = rd_addr;
    if (valid_dmac && tc_set) tcset_cnt++;
    if (valid_dmac && tc_set && kc < 9) begin
      ccoef[kc] = input_data; kc++;
    end else if (valid_dmac && !tc_set) begin
      cpix[pc] = input_data; pc++;
      if (pc == 9) begin
        pc = 0; last_pix_cyc = cyc; waiting = 1;
        if (core_en) left = core_delay;
      end
    end
    if (mon_en) begin
      if (waiting && !(valid_dmac && !tc_set)) begin
        total++;
        if (rd_en !== 1'b0) begin bad++; $display("FAIL rd_in_wait: rd_en=%b required 0", rd_en); end
      end
      if (rd_en) begin
        total++;
        if (rd_q.size() == 0) begin bad++; $display("FAIL rd_extra: addr=%0d required none", rd_addr); end
        else begin
          logic [AW-1:0] ea;
          ea = rd_q.pop_front();
          if (rd_addr !== ea) begin bad++; $display("FAIL rd_addr: got %0d required %0d", rd_addr, ea); end
        end
      end
      total++;
      if (valid_dmac) begin
        if (in_q.size() == 0) begin bad++; $display("FAIL in_extra: data=%h", input_data); end
        else begin
          logic [N:0] ei;
          ei = in_q.pop_front();
          if ({tc_set, input_data} !== ei) begin
            bad++; $display("FAIL in_data: got tc=%b %h required tc=%b %h", tc_set, input_data, ei[N], ei[N-1:0]);
          end
        end
      end else if (input_data !== '0) begin
        bad++; $display("FAIL in_idle: got %h required 0", input_data);
      end
      if (wr_en) begin
        total += 2;
        if (wr_q.size() == 0) begin bad++; $display("FAIL wr_extra: addr=%0d", wr_addr); end
        else begin
          logic [AW+N-1:0] ew;
          ew = wr_q.pop_front();
          if ({wr_addr, wr_data} !== ew) begin
            bad++; $display("FAIL wr: got %0d/%h required %0d/%h", wr_addr, wr_data, ew[AW+N-1:N], ew[N-1:0]);
          end
        end
        if (vc_prev !== 1'b1) begin bad++; $display("FAIL wr_timing: valid_core prev=%b required 1", vc_prev); end
        wr_cyc.push_back(cyc);
      end
    end
    if (wr_en) begin
      mem[wr_addr] = wr_data; wr_cnt++; waiting = 0;
    end
    if (done) done_cnt++;
    vc_prev = valid_core;
  end

  task automatic clear_env();
    rd_q.delete(); in_q.delete(); wr_q.delete(); wr_cyc.delete();
    kc = 0; pc = 0; left = 0; waiting = 0; wr_cnt = 0; done_cnt = 0; tcset_cnt = 0;
  endtask

  task automatic load_img(input logic [AW-1:0] tcb, input logic [AW-1:0] srcb, input bit ident);
    for (int k = 0; k < 9; k++)
      mem[AW'(tcb + AW'(k))] = ident ? ((k == 4) ? 24'h000001 : 24'h0) :
        {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
    for (int p = 0; p < W * H; p++)
      mem[AW'(srcb + AW'(p))] = ident ? N'(p) : N'($urandom);
  endtask

  task automatic push_exp(input logic [AW-1:0] tcb, input logic [AW-1:0] srcb, input logic [AW-1:0] dstb);
    logic [8:0][N-1:0] cf, px;
    logic [AW-1:0] a;
    for (int k = 0; k < 9; k++) begin
      a = tcb + AW'(k);
      rd_q.push_back(a); in_q.push_back({1'b1, mem[a]}); cf[k] = mem[a];
    end
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            a = srcb + AW'((r + i) * W + c + j);
            rd_q.push_back(a); in_q.push_back({1'b0, mem[a]}); px[i*3+j] = mem[a];
          end
        wr_q.push_back({dstb + AW'(r * (W - 2) + c), conv(cf, px)});
      end
  endtask

  task automatic run_job(input logic [AW-1:0] tcb, input logic [AW-1:0] srcb, input logic [AW-1:0] dstb,
                         input int d, input bit poke);
    int n;
    clear_env();
    core_delay = d; core_en = 1;
    push_exp(tcb, srcb, dstb);
    @(negedge clk);
    mon_en = 1;
    tc_base = tcb; src_base = srcb; dst_base = dstb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, rd_en} !== 2'b11) begin bad++; $display("FAIL start_lat: busy/rd_en=%b required 11", {busy, rd_en}); end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (poke && n == 15) begin start = 1'b1; tc_base = 12'h7; src_base = 12'h9; dst_base = 12'h3; end
      else start = 1'b0;
    end
    total++;
    if (n >= 3000) begin bad++; $display("FAIL done_timeout: no done within %0d cycles", n); end
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done: busy=%b required 0", busy); end
    if (wr_cyc.size() == 0 || wr_cyc[wr_cyc.size()-1] != cyc - 1) begin
      bad++; $display("FAIL done_lat: done cycle %0d, last write not in previous cycle", cyc);
    end
    for (int k = 1; k < wr_cyc.size(); k++) begin
      total++;
      if (wr_cyc[k] - wr_cyc[k-1] != 11 + d) begin
        bad++; $display("FAIL pixel_period: got %0d required %0d", wr_cyc[k] - wr_cyc[k-1], 11 + d);
      end
    end
    repeat (3) @(negedge clk);
    mon_en = 0;
    total += 3;
    if (done_cnt != 1) begin bad++; $display("FAIL done_count: got %0d required 1", done_cnt); end
    if (wr_cnt != NOUT) begin bad++; $display("FAIL wr_count: got %0d required %0d", wr_cnt, NOUT); end
    if (rd_q.size() + in_q.size() + wr_q.size() != 0) begin
      bad++; $display("FAIL leftover: rd=%0d in=%0d wr=%0d required 0", rd_q.size(), in_q.size(), wr_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    total += 3;
    if ({rd_en, valid_dmac, tc_set, wr_en, busy, done} !== 6'b0) begin
      bad++; $display("FAIL %s_ctl: got %b required 000000", tag, {rd_en, valid_dmac, tc_set, wr_en, busy, done});
    end
    if ({rd_addr, wr_addr} !== '0) begin bad++; $display("FAIL %s_addr: got %h/%h required 0", tag, rd_addr, wr_addr); end
    if ({input_data, wr_data} !== '0) begin bad++; $display("FAIL %s_data: got %h/%h required 0", tag, input_data, wr_data); end
  endtask

  task automatic test_reset();
    int nr, n;
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    clear_env(); core_en = 1; core_delay = 2;
    load_img(12'd16, 12'd64, 1'b0);
    @(negedge clk);
    tc_base = 12'd16; src_base = 12'd64; dst_base = 12'd256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nr = 1; n = 0;
    while (nr < 13 && n < 100) begin @(negedge clk); n++; if (rd_en) nr++; end
    rst = 1'b1;
    #1;
    check_zero("rst_fetch");
    @(negedge clk);
    check_zero("rst_hold");
    total++;
    if (wr_cnt != 0 || done_cnt != 0) begin bad++; $display("FAIL rst_abort: writes=%0d done=%0d required 0/0", wr_cnt, done_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [N-1:0] idv [4];
    idv = '{24'd5, 24'd6, 24'd9, 24'd10};
    load_img(12'd16, 12'd64, 1'b1);
    for (int k = 0; k < 4; k++) mem[256 + k] = 24'hdeadbe;
    run_job(12'd16, 12'd64, 12'd256, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (mem[256 + k] !== idv[k]) begin bad++; $display("FAIL identity[%0d]: got %h required %h", k, mem[256 + k], idv[k]); end
    end
  endtask

  task automatic test_read_order();
    load_img(12'd100, 12'd200, 1'b0);
    run_job(12'd100, 12'd200, 12'd300, 3, 1'b0);
    total++;
    if (tcset_cnt != 9) begin bad++; $display("FAIL tc_set_count: got %0d required 9", tcset_cnt); end
  endtask

  task automatic test_wrap();
    load_img(12'd50, 12'd4094, 1'b0);
    run_job(12'd50, 12'd4094, 12'd500, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_img(12'd100, 12'd1000, 1'b0);
    run_job(12'd100, 12'd1000, 12'd1200, 7, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    clear_env(); core_en = 0;
    load_img(12'd20, 12'd600, 1'b0);
    @(negedge clk);
    tc_base = 12'd20; src_base = 12'd600; dst_base = 12'd700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!waiting && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!waiting) begin bad++; $display("FAIL tmo_window: window never completed"); end
`ifdef FIR_DMAC_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total += 3;
    if (cyc - last_pix_cyc != 17) begin bad++; $display("FAIL tmo_lat: done %0d cycles after last word, required 17", cyc - last_pix_cyc); end
    if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: err=%b required 1", err); end
    if (wr_cnt != 0) begin bad++; $display("FAIL tmo_write: writes=%0d required 0", wr_cnt); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear: err=%b required 0", err); end
`else
    repeat (40) @(negedge clk);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL tmo_busy: busy=%b required 1", busy); end
    if (wr_cnt != 0 || done_cnt != 0) begin bad++; $display("FAIL tmo_write: writes=%0d done=%0d required 0/0", wr_cnt, done_cnt); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_env();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tc_base = '0; src_base = '0; dst_base = '0;
    rd_data = '0; output_data = '0; valid_core = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    test_reset();
    test_identity();
    test_read_order();
    test_wrap();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
